// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry constants, the byte-matrix state
// type, the FSM state enum, the forward S-box and GF(2^8) xtime.
package aes_pkg;

  localparam int NB       = 4;
  localparam int NR_192   = 12;
  localparam int RK_W_192 = 4 * (NR_192 + 1) * 32;

  // [column][row] byte matrix; element [0][0] is the most significant byte so a
  // 128-bit block maps straight onto it in FIPS-197 column-major order.
  typedef logic [0:3][0:3][7:0] state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns
// (skipped when last_round is high) and AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  state_t             state_in,
  input  logic [32*NB-1:0]   round_key,
  input  logic               last_round,
  output state_t             state_out
);

  state_t sub_shift;
  state_t mixed;

  // SubBytes then ShiftRows: row r of the result rotates left by r columns.
  always_comb begin
    sub_shift = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub_shift[c][r] = sbox(state_in[(c + r) % 4][r]);
      end
    end
  end

  // MixColumns with the {02,03,01,01} circulant on each column.
  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[c][0] = xtime(sub_shift[c][0]) ^ xtime(sub_shift[c][1]) ^ sub_shift[c][1]
                  ^ sub_shift[c][2] ^ sub_shift[c][3];
      mixed[c][1] = sub_shift[c][0] ^ xtime(sub_shift[c][1]) ^ xtime(sub_shift[c][2])
                  ^ sub_shift[c][2] ^ sub_shift[c][3];
      mixed[c][2] = sub_shift[c][0] ^ sub_shift[c][1] ^ xtime(sub_shift[c][2])
                  ^ xtime(sub_shift[c][3]) ^ sub_shift[c][3];
      mixed[c][3] = xtime(sub_shift[c][0]) ^ sub_shift[c][0] ^ sub_shift[c][1]
                  ^ sub_shift[c][2] ^ xtime(sub_shift[c][3]);
    end
  end

  assign state_out = (last_round ? sub_shift : mixed) ^ round_key;

endmodule

// File: rtl/aes192_encrypt_iter.sv
// Iterative AES-192 encryption core, one round per clock, valid/ready on both
// sides. Define AES192_KEY_LATCH_EN to capture the round-key schedule on
// accept; otherwise the schedule is read live and must be held by upstream
// until the output handshake.
module aes192_encrypt_iter
  import aes_pkg::*;
#(
  parameter int NB   = aes_pkg::NB,
  parameter int NR   = aes_pkg::NR_192,
  parameter int RK_W = aes_pkg::RK_W_192
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*NB-1:0]    plaintext,
  input  logic [RK_W-1:0]     round_keys,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*NB-1:0]    ciphertext,
  output logic                busy
);

  fsm_t               fsm;
  logic [3:0]         rnd;
  state_t             blk;
  state_t             round_out;
  logic [RK_W-1:0]    rk_src;
  logic [32*NB-1:0]   rk_sel;
  logic               accept;

  assign accept = in_valid & in_ready;

`ifdef AES192_KEY_LATCH_EN
  logic [RK_W-1:0] rk_q;

  // Hold the schedule for the whole block so upstream is free after accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rk_q <= '0;
    end else if (accept) begin
      rk_q <= round_keys;
    end
  end

  assign rk_src = rk_q;
`else
  assign rk_src = round_keys;
`endif

  // Select rk[rnd]; only 1..NR are meaningful while rounds are running.
  always_comb begin
    rk_sel = '0;
    for (int r = 1; r <= NR; r++) begin
      if (rnd == 4'(r)) begin
        rk_sel = rk_src[RK_W-1-128*r -: 128];
      end
    end
  end

  aes_round u_round (
    .state_in   (blk),
    .round_key  (rk_sel),
    .last_round (rnd == 4'(NR)),
    .state_out  (round_out)
  );

  // Control FSM with registered handshake/status outputs and the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm       <= IDLE;
      rnd       <= '0;
      blk       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            // Initial AddRoundKey always uses rk[0] straight from the port.
            blk      <= state_t'(plaintext ^ round_keys[RK_W-1 -: 128]);
            rnd      <= 4'd1;
            fsm      <= ROUND;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ROUND: begin
          blk <= round_out;
          rnd <= rnd + 4'd1;
          if (rnd == 4'(NR)) begin
            rnd       <= '0;
            fsm       <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            // Clearing the block keeps ciphertext at zero while idle.
            blk       <= '0;
            fsm       <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          fsm <= IDLE;
        end
      endcase
    end
  end

  assign ciphertext = blk;

endmodule

// File: tb/tb_aes192_encrypt_iter.sv
// Self-checking bench for aes192_encrypt_iter with a reference AES-192 model
// (S-box derived from GF inverse + affine map) and an expected-result queue.
module tb_aes192_encrypt_iter;

  localparam logic [127:0] C2_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2_CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [191:0] C2_KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam int           LIM    = 40;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   plaintext;
  logic [1663:0]  round_keys;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   ciphertext;
  logic           busy;

  int             checks = 0;
  int             errors = 0;
  logic [127:0]   exp_q[$];
  logic [1663:0]  c2_rk;

  always #5 clk = ~clk;

  aes192_encrypt_iter dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .round_keys (round_keys),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gmul(inv, inv);
      if (i != 0) inv = gmul(inv, a);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [1663:0] key_expand(input logic [191:0] key);
    logic [31:0]   w[52];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1663:0] rk;
    rcon = 8'h01;
    for (int i = 0; i < 6; i++) w[i] = key[191-32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = w[i-1];
      if (i % 6 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {ref_sbox(t[31:24]) ^ rcon, ref_sbox(t[23:16]), ref_sbox(t[15:8]), ref_sbox(t[7:0])};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-6] ^ t;
    end
    rk = '0;
    for (int i = 0; i < 52; i++) rk[1663-32*i -: 32] = w[i];
    return rk;
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [1663:0] rk);
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[1663-8*i -: 8];
    for (int rd = 1; rd <= 12; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = ref_sbox(s[i]);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rd < 12) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[1663-128*rd-8*i -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- drive helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ready(output int n);
    n = 0;
    while (in_ready !== 1'b1 && n < LIM) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < LIM) begin
      tick();
      n++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tick();
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (ciphertext !== 128'h0) begin errors++; $display("FAIL reset_ciphertext got %h want 0", ciphertext); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy got %b want 0", busy); end
  endtask

  task automatic test_c2();
    int n;
    logic [127:0] exp;
    out_ready = 1'b1;
    wait_in_ready(n);
    checks++; if (n >= LIM) begin errors++; $display("FAIL c2_ready_timeout got %0d want <%0d", n, LIM); end
    plaintext  = C2_PT;
    round_keys = c2_rk;
    in_valid   = 1'b1;
    exp_q.push_back(C2_CT);
    tick();
    in_valid  = 1'b0;
    plaintext = '0;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL c2_busy got busy=%b in_ready=%b want 1/0", busy, in_ready); end
    wait_out_valid(n);
    checks++; if (n !== 12) begin errors++; $display("FAIL c2_latency got %0d want 12", n); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    checks++; if (ciphertext !== exp) begin errors++; $display("FAIL c2_ct got %h want %h", ciphertext, exp); end
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL c2_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_backpressure();
    int n;
    logic [127:0] pt;
    logic [127:0] exp;
    out_ready = 1'b0;
    wait_in_ready(n);
    checks++; if (n >= LIM) begin errors++; $display("FAIL bp_ready_timeout got %0d want <%0d", n, LIM); end
    pt = rand128();
    plaintext = pt;
    in_valid  = 1'b1;
    exp_q.push_back(model_encrypt(pt, c2_rk));
    tick();
    in_valid = 1'b0;
    wait_out_valid(n);
    checks++; if (n !== 12) begin errors++; $display("FAIL bp_latency got %0d want 12", n); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    checks++; if (ciphertext !== exp) begin errors++; $display("FAIL bp_ct got %h want %h", ciphertext, exp); end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || ciphertext !== exp || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got ov=%b ct=%h ir=%b busy=%b want 1/%h/0/1", i, out_valid, ciphertext, in_ready, busy, exp);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || ciphertext !== 128'h0) begin
      errors++;
      $display("FAIL bp_release got ir=%b ov=%b busy=%b ct=%h want 1/0/0/0", in_ready, out_valid, busy, ciphertext);
    end
  endtask

  task automatic test_ignored_input();
    int n;
    logic [127:0] pt;
    logic [127:0] exp;
    out_ready = 1'b1;
    wait_in_ready(n);
    checks++; if (n >= LIM) begin errors++; $display("FAIL ign_ready_timeout got %0d want <%0d", n, LIM); end
    pt = rand128();
    plaintext = pt;
    in_valid  = 1'b1;
    exp_q.push_back(model_encrypt(pt, c2_rk));
    tick();
    n = 0;
    while (out_valid !== 1'b1 && n < LIM) begin
      plaintext = rand128();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ign_in_ready cycle %0d got %b want 0", n, in_ready); end
      tick();
      n++;
    end
    in_valid = 1'b0;
    checks++; if (n !== 12) begin errors++; $display("FAIL ign_latency got %0d want 12", n); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    checks++; if (ciphertext !== exp) begin errors++; $display("FAIL ign_ct got %h want %h", ciphertext, exp); end
    tick();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ign_release got ir=%b busy=%b want 1/0", in_ready, busy); end
  endtask

  task automatic test_back_to_back();
    int n;
    int cyc;
    int acc_cnt;
    int got;
    int last_acc;
    bit just_acc;
    logic [127:0] pt;
    logic [127:0] exp;
    cyc = 0; acc_cnt = 0; got = 0; last_acc = -1; just_acc = 1'b0;
    out_ready = 1'b1;
    wait_in_ready(n);
    checks++; if (n >= LIM) begin errors++; $display("FAIL b2b_ready_timeout got %0d want <%0d", n, LIM); end
    pt = rand128();
    plaintext = pt;
    in_valid  = 1'b1;
    while ((acc_cnt < 4 || got < 4) && cyc < 200) begin
      if (just_acc) begin
        pt = rand128();
        plaintext = pt;
        if (acc_cnt >= 4) in_valid = 1'b0;
        just_acc = 1'b0;
      end
      if (out_valid === 1'b1) begin
        got++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        checks++; if (ciphertext !== exp) begin errors++; $display("FAIL b2b_ct block %0d got %h want %h", got, ciphertext, exp); end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        exp_q.push_back(model_encrypt(pt, c2_rk));
        if (last_acc >= 0) begin
          checks++; if (cyc - last_acc != 14) begin errors++; $display("FAIL b2b_interval got %0d want 14", cyc - last_acc); end
        end
        last_acc = cyc;
        acc_cnt++;
        just_acc = 1'b1;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (cyc >= 200) begin errors++; $display("FAIL b2b_timeout got acc=%0d out=%0d want 4/4", acc_cnt, got); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [127:0] exp;
    out_ready = 1'b1;
    wait_in_ready(n);
    checks++; if (n >= LIM) begin errors++; $display("FAIL rst_ready_timeout got %0d want <%0d", n, LIM); end
    plaintext  = C2_PT;
    round_keys = c2_rk;
    in_valid   = 1'b1;
    exp_q.push_back(C2_CT);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b want 1", busy); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_async_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_out_valid got %b want 0", out_valid); end
    checks++; if (ciphertext !== 128'h0) begin errors++; $display("FAIL rst_async_ct got %h want 0", ciphertext); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got %b want 0", busy); end
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    wait_in_ready(n);
    checks++; if (n >= LIM) begin errors++; $display("FAIL rst_rerun_ready_timeout got %0d want <%0d", n, LIM); end
    exp_q.push_back(C2_CT);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out_valid(n);
    checks++; if (n !== 12) begin errors++; $display("FAIL rst_rerun_latency got %0d want 12", n); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    checks++; if (ciphertext !== exp) begin errors++; $display("FAIL rst_rerun_ct got %h want %h", ciphertext, exp); end
    tick();
  endtask

`ifdef AES192_KEY_LATCH_EN
  task automatic test_key_latch();
    int n;
    logic [127:0] exp;
    out_ready = 1'b1;
    wait_in_ready(n);
    checks++; if (n >= LIM) begin errors++; $display("FAIL kl_ready_timeout got %0d want <%0d", n, LIM); end
    plaintext  = C2_PT;
    round_keys = c2_rk;
    in_valid   = 1'b1;
    exp_q.push_back(C2_CT);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < LIM) begin
      for (int i = 0; i < 52; i++) round_keys[32*i +: 32] = $urandom();
      tick();
      n++;
    end
    checks++; if (n !== 12) begin errors++; $display("FAIL kl_latency got %0d want 12", n); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    checks++; if (ciphertext !== exp) begin errors++; $display("FAIL kl_ct got %h want %h", ciphertext, exp); end
    tick();
    round_keys = c2_rk;
  endtask
`endif

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    plaintext  = '0;
    round_keys = '0;
    c2_rk      = key_expand(C2_KEY);
    test_reset();
    test_c2();
    test_backpressure();
    test_ignored_input();
    test_back_to_back();
    test_reset_mid();
`ifdef AES192_KEY_LATCH_EN
    test_key_latch();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation watchdog expired");
  end

endmodule
